// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers.
// Holds the default 640x480@60 vertical region lengths, the default
// horizontal counter width and a function that totals the four region
// lengths of a frame.
package vga_timing_pkg;

  localparam int VGA_V_LINES       = 480;
  localparam int VGA_V_FRONT_PORCH = 10;
  localparam int VGA_V_SYNC_WIDTH  = 2;
  localparam int VGA_V_BACK_PORCH  = 33;
  localparam int VGA_H_COUNT_W     = 10;

  function automatic int vga_total(input int visible, input int front,
                                   input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_vsync_if.sv
// Line-rate timing bundle between the horizontal counter, the vertical
// generator and its consumers.
//   h_count  - horizontal pixel counter from the horizontal block
//   v_count  - current line index
//   v_blank  - high outside the visible lines
//   vsync    - vertical sync, polarity chosen by the generator
// master: the vertical generator; slave: the horizontal source / consumer.
interface vga_vsync_if #(
  parameter int H_COUNT_W = 10,
  parameter int V_COUNT_W = 10
);

  logic [H_COUNT_W-1:0] h_count;
  logic [V_COUNT_W-1:0] v_count;
  logic                 v_blank;
  logic                 vsync;

  modport master (
    input  h_count,
    output v_count,
    output v_blank,
    output vsync
  );

  modport slave (
    output h_count,
    input  v_count,
    input  v_blank,
    input  vsync
  );

endinterface

// File: rtl/vga_wrap_detect.sv
// Detects the first cycle of a new line from a free-running horizontal
// counter: line_tick is high when h_count is 0 and the previous cycle's
// value was nonzero. Any transition into 0 from a nonzero value counts.
// Ports:
//   clk_in    - pixel clock
//   reset     - asynchronous, active-high reset
//   h_count   - horizontal counter, synchronous to clk_in
//   line_tick - one-cycle pulse on the first cycle of each new line
module vga_wrap_detect #(
  parameter int W = 10
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic [W-1:0] h_count,
  output logic         line_tick
);

  logic [W-1:0] h_prev;

  // h_prev resets to 0 so a counter parked at 0 after reset is not a wrap.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) h_prev <= '0;
    else       h_prev <= h_count;
  end

  assign line_tick = (h_count == '0) && (h_prev != '0);

endmodule

// File: rtl/vga_vsync.sv
// Vertical timing generator. Counts lines on each horizontal wrap and
// produces the line index, vertical blanking and vertical sync.
// Ports:
//   clk_in - pixel clock, all state on the rising edge
//   reset  - asynchronous, active-high reset
//   bus    - master side of vga_vsync_if (h_count in; v_count, v_blank,
//            vsync out). All outputs are registered.
module vga_vsync
  import vga_timing_pkg::*;
#(
  parameter int LINES            = VGA_V_LINES,
  parameter int FRONT_PORCH      = VGA_V_FRONT_PORCH,
  parameter int VSYNC_WIDTH      = VGA_V_SYNC_WIDTH,
  parameter int BACK_PORCH       = VGA_V_BACK_PORCH,
  parameter int H_COUNT_W        = VGA_H_COUNT_W,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic         clk_in,
  input  logic         reset,
  vga_vsync_if.master  bus
);

  localparam int V_TOTAL   = vga_total(LINES, FRONT_PORCH, VSYNC_WIDTH, BACK_PORCH);
  localparam int V_COUNT_W = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  // One spare bit so the region boundaries never wrap in the compares.
  localparam int CMP_W     = V_COUNT_W + 1;

  localparam logic [CMP_W-1:0] LAST_LINE  = CMP_W'(V_TOTAL - 1);
  localparam logic [CMP_W-1:0] VIS_END    = CMP_W'(LINES);
  localparam logic [CMP_W-1:0] SYNC_START = CMP_W'(LINES + FRONT_PORCH);
  localparam logic [CMP_W-1:0] SYNC_END   = CMP_W'(LINES + FRONT_PORCH + VSYNC_WIDTH);

  localparam logic VS_ON  = VSYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic VS_OFF = ~VS_ON;

  if (LINES < 1 || VSYNC_WIDTH < 1) begin : g_param_check
    $error("vga_vsync: LINES and VSYNC_WIDTH must both be >= 1");
  end

  logic                 line_tick;
  logic [V_COUNT_W-1:0] v_count_q;
  logic [V_COUNT_W-1:0] v_next;
  logic [CMP_W-1:0]     n_ext;
  logic                 blank_next;
  logic                 sync_next;
  logic                 v_blank_q;
  logic                 vsync_q;

  vga_wrap_detect #(.W(H_COUNT_W)) u_wrap (
    .clk_in    (clk_in),
    .reset     (reset),
    .h_count   (bus.h_count),
    .line_tick (line_tick)
  );

  // Blank/sync are decoded from the next line index so that all three
  // outputs change on the same edge.
  always_comb begin
    v_next = v_count_q;
    if (line_tick) begin
      v_next = ({1'b0, v_count_q} == LAST_LINE) ? '0 : v_count_q + 1'b1;
    end
    n_ext      = {1'b0, v_next};
    blank_next = (n_ext >= VIS_END);
    sync_next  = (n_ext >= SYNC_START) && (n_ext < SYNC_END);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      v_count_q <= '0;
      v_blank_q <= 1'b0;
      vsync_q   <= VS_OFF;
    end else begin
      v_count_q <= v_next;
      v_blank_q <= blank_next;
      vsync_q   <= sync_next ? VS_ON : VS_OFF;
    end
  end

  assign bus.v_count = v_count_q;
  assign bus.v_blank = v_blank_q;
  assign bus.vsync   = vsync_q;

endmodule

// File: tb/tb_vga_vsync.sv
module tb_vga_vsync;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic [3:0] hc     = 4'd0;
  bit         free_run = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  // Hand-computed region table for LINES=6, FP=1, VW=2, BP=1.
  bit exp_blank [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
  bit exp_vs_lo [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1};
  bit exp_vs_hi [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};

  vga_vsync_if #(.H_COUNT_W(4), .V_COUNT_W(4)) bus_a ();
  vga_vsync_if #(.H_COUNT_W(4), .V_COUNT_W(4)) bus_b ();

  assign bus_a.h_count = hc;
  assign bus_b.h_count = hc;

  vga_vsync #(
    .LINES(6), .FRONT_PORCH(1), .VSYNC_WIDTH(2), .BACK_PORCH(1),
    .H_COUNT_W(4), .VSYNC_ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus_a)
  );

  vga_vsync #(
    .LINES(6), .FRONT_PORCH(1), .VSYNC_WIDTH(2), .BACK_PORCH(1),
    .H_COUNT_W(4), .VSYNC_ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus_b)
  );

  always #5 clk_in = ~clk_in;

  // One clock: outputs of this edge are stable on return, then h_count
  // advances for the next edge when free-running.
  task automatic clk1();
    @(posedge clk_in);
    #1;
    if (free_run) hc = hc + 4'd1;
  endtask

  task automatic check_line(input string tag, input int line);
    n_checks++;
    if (bus_a.v_count !== 4'(line)) $display("FAIL %s v_count: got %0d want %0d", tag, bus_a.v_count, line);
    else n_pass++;
    n_checks++;
    if (bus_a.v_blank !== exp_blank[line]) $display("FAIL %s v_blank line %0d: got %b want %b", tag, line, bus_a.v_blank, exp_blank[line]);
    else n_pass++;
    n_checks++;
    if (bus_a.vsync !== exp_vs_lo[line]) $display("FAIL %s vsync_lo line %0d: got %b want %b", tag, line, bus_a.vsync, exp_vs_lo[line]);
    else n_pass++;
    n_checks++;
    if (bus_b.vsync !== exp_vs_hi[line]) $display("FAIL %s vsync_hi line %0d: got %b want %b", tag, line, bus_b.vsync, exp_vs_hi[line]);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hc = 4'd0;
    free_run = 1'b0;
    repeat (2) clk1();
    check_line("reset", 0);
    reset = 1'b0;
    repeat (3) clk1();
    n_checks++;
    if (bus_a.v_count !== 4'd0) $display("FAIL idle_after_reset v_count: got %0d want 0", bus_a.v_count);
    else n_pass++;
  endtask

  task automatic test_line_stepping();
    free_run = 1'b1;
    clk1();
    for (int line = 1; line <= 9; line++) begin
      repeat (15) clk1();
      n_checks++;
      if (bus_a.v_count !== 4'(line - 1)) $display("FAIL pre_wrap v_count: got %0d want %0d", bus_a.v_count, line - 1);
      else n_pass++;
      clk1();
      check_line("step", line);
    end
  endtask

  task automatic test_frame_wrap();
    int pulses;
    int len;
    int hi_cycles;
    bit prev;
    repeat (16) clk1();
    check_line("wrap", 0);
    pulses = 0;
    len = 0;
    hi_cycles = 0;
    prev = bus_a.vsync;
    for (int i = 0; i < 480; i++) begin
      clk1();
      if (prev && !bus_a.vsync) begin
        pulses++;
        len = 0;
      end
      if (!bus_a.vsync) len++;
      if (!prev && bus_a.vsync) begin
        n_checks++;
        if (len !== 32) $display("FAIL pulse_len: got %0d want 32", len);
        else n_pass++;
      end
      if (bus_b.vsync) hi_cycles++;
      prev = bus_a.vsync;
    end
    n_checks++;
    if (pulses !== 3) $display("FAIL pulse_count: got %0d want 3", pulses);
    else n_pass++;
    n_checks++;
    if (hi_cycles !== 96) $display("FAIL hi_pol_cycles: got %0d want 96", hi_cycles);
    else n_pass++;
    check_line("three_frames", 0);
  endtask

  task automatic test_reset_mid_sync();
    repeat (7 * 16) clk1();
    check_line("before_reset", 7);
    #2;
    reset = 1'b1;
    #1;
    check_line("async_reset", 0);
    free_run = 1'b0;
    hc = 4'd0;
    repeat (2) clk1();
    reset = 1'b0;
    free_run = 1'b1;
    clk1();
    repeat (15) clk1();
    check_line("restart_pre", 0);
    clk1();
    check_line("restart", 1);
  endtask

  task automatic test_hold_and_nonmonotonic();
    free_run = 1'b0;
    hc = 4'd9;
    repeat (40) clk1();
    check_line("hold", 1);
    hc = 4'd3;
    clk1();
    hc = 4'd0;
    clk1();
    check_line("nonmono_1", 2);
    repeat (5) clk1();
    check_line("zero_hold", 2);
    hc = 4'd5;
    clk1();
    hc = 4'd0;
    clk1();
    check_line("nonmono_2", 3);
  endtask

  initial begin
    test_reset();
    test_line_stepping();
    test_frame_wrap();
    test_reset_mid_sync();
    test_hold_and_nonmonotonic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
